// File: rtl/score_display_pkg.sv
// Shared definitions for the score display: segment codes, FSM states and the
// per-digit segment encoder.
package score_display_pkg;

    localparam int BCD_NIBBLE_W = 4;

    // Segment patterns with lit = 1, bit order {A,B,C,D,E,F,G}
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } state_t;

    // Non-decimal nibbles render as a blank digit
    function automatic logic [6:0] seg_encode(input logic [BCD_NIBBLE_W-1:0] nibble);
        case (nibble)
            4'd0:    seg_encode = SEG_0;
            4'd1:    seg_encode = SEG_1;
            4'd2:    seg_encode = SEG_2;
            4'd3:    seg_encode = SEG_3;
            4'd4:    seg_encode = SEG_4;
            4'd5:    seg_encode = SEG_5;
            4'd6:    seg_encode = SEG_6;
            4'd7:    seg_encode = SEG_7;
            4'd8:    seg_encode = SEG_8;
            4'd9:    seg_encode = SEG_9;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

    // 10^n, used to derive the largest displayable value
    function automatic int pow10(input int n);
        pow10 = 1;
        for (int i = 0; i < n; i++) pow10 = pow10 * 10;
    endfunction

endpackage

// File: rtl/score_bcd_display_if.sv
// Score-in / segments-out bundle between the game logic and the display driver.
interface score_bcd_display_if #(
    parameter int SCORE_W = 7,
    parameter int DIGITS  = 2
);
    logic [SCORE_W-1:0]  i_Score;
    logic [7*DIGITS-1:0] o_Segments;
    logic                o_Busy;
    logic                o_Overflow;

    modport master (output i_Score, input  o_Segments, o_Busy, o_Overflow);
    modport slave  (input  i_Score, output o_Segments, o_Busy, o_Overflow);
endinterface

// File: rtl/score_bcd_display_bin2bcd_dd.sv
// Sequential double-dabble binary-to-BCD engine: loads on i_Start, then shifts
// one score bit per cycle for SCORE_W cycles and pulses o_Done for one cycle.
module bin2bcd_dd
    import score_display_pkg::*;
#(
    parameter int SCORE_W = 7,
    parameter int DIGITS  = 2
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst_N,
    input  logic                           i_Start,
    input  logic [SCORE_W-1:0]             i_Bin,
    output logic                           o_Busy,
    output logic                           o_Done,
    output logic [BCD_NIBBLE_W*DIGITS-1:0] o_Bcd
);

    localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
    localparam int CNT_W = $clog2(SCORE_W + 1);

    logic [SCORE_W-1:0] bin_sr;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;

    // Add 3 to every nibble >= 5 ahead of the shift
    always_comb begin
        // NOTE: default first so every path assigns bcd_adj and no latch is inferred.
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[k*BCD_NIBBLE_W +: BCD_NIBBLE_W] >= 4'd5)
                bcd_adj[k*BCD_NIBBLE_W +: BCD_NIBBLE_W] = bcd_q[k*BCD_NIBBLE_W +: BCD_NIBBLE_W] + 4'd3;
        end
    end

    // Load on start, then shift one bit per cycle; bits leaving the BCD MSB are dropped
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            bin_sr <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            done_q <= 1'b0;
            if (i_Start) begin
                bin_sr <= i_Bin;
                bcd_q  <= '0;
                cnt_q  <= CNT_W'(SCORE_W);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                bcd_q  <= (bcd_adj << 1) | BCD_W'(bin_sr[SCORE_W-1]);
                bin_sr <= bin_sr << 1;
                cnt_q  <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign o_Busy = busy_q;
    assign o_Done = done_q;
    assign o_Bcd  = bcd_q;

endmodule

// File: rtl/score_bcd_display.sv
// Multi-digit 7-segment score driver. Captures the score when it changes,
// converts it to BCD, saturates to all 9s when out of range, and registers one
// segment pattern per digit (digit 0 = units) so the pins never glitch.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module score_bcd_display
    import score_display_pkg::*;
#(
    parameter int SCORE_W    = 7,
    parameter int DIGITS     = 2,
    parameter int ACTIVE_LOW = 1
) (
    input logic                i_Clk,
    input logic                i_Rst_N,
    score_bcd_display_if.slave bus
);

    localparam int BCD_W    = BCD_NIBBLE_W * DIGITS;
    localparam int SEG_W    = 7 * DIGITS;
    localparam int MAX_DISP = pow10(DIGITS) - 1;
    localparam int CMP_W    = (SCORE_W > 32) ? SCORE_W : 32;
    localparam logic [SEG_W-1:0] SEG_OFF = {SEG_W{ACTIVE_LOW != 0}};

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q;
    logic               init_q;
    logic               ovf_cap_q;
    logic               capture;
    logic               over_range;
    logic               dd_busy, dd_done;
    logic [BCD_W-1:0]   dd_bcd;
    logic [BCD_W-1:0]   disp_bcd;
    logic [SEG_W-1:0]   seg_d, seg_q;
    logic               ovf_q;
    logic [6:0]         lit;
`ifdef LEADING_ZERO_BLANK_EN
    logic               lead;
`endif

    assign over_range = CMP_W'(bus.i_Score) > CMP_W'(MAX_DISP);

    bin2bcd_dd #(
        .SCORE_W(SCORE_W),
        .DIGITS (DIGITS)
    ) u_dd (
        .i_Clk  (i_Clk),
        .i_Rst_N(i_Rst_N),
        .i_Start(capture),
        .i_Bin  (bus.i_Score),
        .o_Busy (dd_busy),
        .o_Done (dd_done),
        .o_Bcd  (dd_bcd)
    );

    // Next-state logic: capture on first run or score change, wait for the engine, publish
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (init_q || (bus.i_Score != score_q)) begin
                    capture = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT:   if (dd_done && !dd_busy) state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus the values latched at capture
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            state_q   <= IDLE;
            score_q   <= '0;
            init_q    <= 1'b1;
            ovf_cap_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                score_q   <= bus.i_Score;
                init_q    <= 1'b0;
                ovf_cap_q <= over_range;
            end
        end
    end

    // Encode the converted (or saturated) digits into pin-level segment patterns
    always_comb begin
        disp_bcd = ovf_cap_q ? {DIGITS{4'h9}} : dd_bcd;
        seg_d    = '0;
        lit      = SEG_BLANK;
`ifdef LEADING_ZERO_BLANK_EN
        lead     = 1'b1;
`endif
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lit = seg_encode(disp_bcd[k*BCD_NIBBLE_W +: BCD_NIBBLE_W]);
`ifdef LEADING_ZERO_BLANK_EN
            if (disp_bcd[k*BCD_NIBBLE_W +: BCD_NIBBLE_W] != 4'd0) lead = 1'b0;
            if (lead && (k != 0)) lit = SEG_BLANK;
`endif
            seg_d[k*7 +: 7] = (ACTIVE_LOW != 0) ? ~lit : lit;
        end
    end

    // Output registers change only in UPDATE, holding the old value during conversion
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            seg_q <= SEG_OFF;
            ovf_q <= 1'b0;
        end else if (state_q == UPDATE) begin
            seg_q <= seg_d;
            ovf_q <= ovf_cap_q;
        end
    end

    assign bus.o_Segments = seg_q;
    assign bus.o_Overflow = ovf_q;
    assign bus.o_Busy     = (state_q != IDLE);

endmodule
